// File: rtl/breakout_status_serializer_pkg.sv
// Shared types and CRC helper for the breakout status serializer.
// CRC-8 (poly 0x07, init 0x00), evaluated MSB first over the low nbits of data.
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_GAP     = 2'd3
  } bss_state_e;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam int         CRC_MAX_BITS = 256;

  function automatic logic [7:0] crc8_calc(input logic [CRC_MAX_BITS-1:0] data,
                                           input int nbits);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = CRC_MAX_BITS - 1; i >= 0; i--) begin
      if (i < nbits) begin
        fb  = crc[7] ^ data[i];
        crc = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/breakout_status_serializer_if.sv
// Front-panel inputs and serial host link of the breakout status serializer.
// The slave side belongs to the serializer, the master side to whoever drives the panel.
interface breakout_status_serializer_if #(
  parameter int NUM_PORT   = 8,
  parameter int NUM_BUTTON = 8,
  parameter int NUM_LINK   = 4,
  parameter int NUM_LANES  = 2
);
  logic [NUM_PORT-1:0]   i_port;
  logic [NUM_BUTTON-1:0] i_button;
  logic [NUM_LINK-1:0]   i_link_pow;
  logic                  o_clk_s;
  logic [NUM_LANES-1:0]  o_d_s;
  logic                  o_frame_done;

  modport master (
    output i_port, i_button, i_link_pow,
    input  o_clk_s, o_d_s, o_frame_done
  );

  modport slave (
    input  i_port, i_button, i_link_pow,
    output o_clk_s, o_d_s, o_frame_done
  );
endinterface

// File: rtl/breakout_status_serializer_sym_timer.sv
// Serial clock divider: o_clk_s low for CLK_DIV cycles then high for CLK_DIV cycles,
// a strobe on each fall point and a per-state symbol counter that wraps on sym_len_m1.
module bss_sym_timer #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [CNT_W-1:0] sym_len_m1,
  output logic             clk_s,
  output logic             sym_stb,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             sym_last
);
  localparam int               DIV_W    = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;

  // div_cnt==0 marks the edge where a new symbol is launched and o_clk_s falls
  assign sym_stb  = (div_cnt == '0);
  assign sym_last = (sym_cnt == sym_len_m1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_cnt <= '0;
      clk_s   <= 1'b0;
      sym_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      clk_s   <= (div_cnt >= DIV_HALF);
      if (sym_stb) begin
        sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/breakout_status_serializer.sv
// Snapshots synchronised port/button/link-power inputs and streams framed words
// over a forwarded serial clock and NUM_LANES lanes. Define BSS_CRC8_EN to append a CRC-8.
//
// state      | meaning
// ST_SYNC    | HDR_LEN symbols of SYNC_WORD on every lane; snapshot taken on the first
// ST_PAYLOAD | padded snapshot word, MSB on lane 0 of the first symbol
// ST_CRC     | CRC-8 of the padded word (BSS_CRC8_EN builds only)
// ST_GAP     | GAP_LEN zero symbols; frame_done on the last one
module breakout_status_serializer
  import breakout_pkg::*;
#(
  parameter int                  NUM_PORT   = 8,
  parameter int                  NUM_BUTTON = 8,
  parameter int                  NUM_LINK   = 4,
  parameter int                  NUM_LANES  = 2,
  parameter int                  CLK_DIV    = 4,
  parameter int                  HDR_LEN    = 4,
  parameter logic [HDR_LEN-1:0]  SYNC_WORD  = 4'b1110,
  parameter int                  GAP_LEN    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  breakout_status_serializer_if.slave   bus
);
  localparam int W       = NUM_LINK + NUM_BUTTON + NUM_PORT;
  localparam int PAY_SYM = (W + NUM_LANES - 1) / NUM_LANES;
  localparam int WP      = PAY_SYM * NUM_LANES;
  localparam int PAD     = WP - W;
`ifdef BSS_CRC8_EN
  localparam int CRC_SYM = 8 / NUM_LANES;
`else
  localparam int CRC_SYM = 0;
`endif
  localparam int M1      = (HDR_LEN > PAY_SYM) ? HDR_LEN : PAY_SYM;
  localparam int M2      = (CRC_SYM > GAP_LEN) ? CRC_SYM : GAP_LEN;
  localparam int MAX_LEN = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam bss_state_e AFTER_DATA = (GAP_LEN > 0) ? ST_GAP : ST_SYNC;
`ifdef BSS_CRC8_EN
  localparam bss_state_e AFTER_PAY  = ST_CRC;
`else
  localparam bss_state_e AFTER_PAY  = AFTER_DATA;
`endif

  logic [W-1:0]         sync1, sync2;
  logic [WP-1:0]        snap;
  bss_state_e           state, state_nxt;
  logic [NUM_LANES-1:0] d_q, d_nxt;
  logic                 done_q, done_nxt;
  logic                 snap_load;
  logic [CNT_W-1:0]     len_m1;
  logic                 clk_s, sym_stb, sym_last;
  logic [CNT_W-1:0]     sym_cnt;

  logic [HDR_LEN-1:0]   hdr_sh;
  logic [WP-1:0]        pay_sh;
  logic [NUM_LANES-1:0] pay_lanes;
`ifdef BSS_CRC8_EN
  logic [7:0]           crc_val, crc_sh;
  logic [NUM_LANES-1:0] crc_lanes;
`endif

  bss_sym_timer #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .sym_len_m1 (len_m1),
    .clk_s      (clk_s),
    .sym_stb    (sym_stb),
    .sym_cnt    (sym_cnt),
    .sym_last   (sym_last)
  );

  assign bus.o_clk_s      = clk_s;
  assign bus.o_d_s        = d_q;
  assign bus.o_frame_done = done_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      snap   <= '0;
      state  <= ST_SYNC;
      d_q    <= '0;
      done_q <= 1'b0;
    end else begin
      sync1  <= {bus.i_link_pow, bus.i_button, bus.i_port};
      sync2  <= sync1;
      if (snap_load) begin
        snap <= WP'(sync2) << PAD;
      end
      state  <= state_nxt;
      d_q    <= d_nxt;
      done_q <= done_nxt;
    end
  end

  // Lane mux: symbol k, lane j carries padded bit WP-1-(k*NUM_LANES+j)
  always_comb begin
    hdr_sh    = SYNC_WORD << sym_cnt;
    pay_sh    = snap << (NUM_LANES * int'(sym_cnt));
    pay_lanes = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      pay_lanes[j] = pay_sh[WP-1-j];
    end
`ifdef BSS_CRC8_EN
    crc_val   = crc8_calc(CRC_MAX_BITS'(snap), WP);
    crc_sh    = crc_val << (NUM_LANES * int'(sym_cnt));
    crc_lanes = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      crc_lanes[j] = crc_sh[7-j];
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    d_nxt     = d_q;
    done_nxt  = 1'b0;
    snap_load = 1'b0;
    case (state)
      ST_SYNC:    len_m1 = CNT_W'(HDR_LEN - 1);
      ST_PAYLOAD: len_m1 = CNT_W'(PAY_SYM - 1);
`ifdef BSS_CRC8_EN
      ST_CRC:     len_m1 = CNT_W'(CRC_SYM - 1);
`endif
      default:    len_m1 = CNT_W'(GAP_LEN - 1);
    endcase
    if (sym_stb) begin
      case (state)
        ST_SYNC: begin
          d_nxt     = {NUM_LANES{hdr_sh[HDR_LEN-1]}};
          snap_load = (sym_cnt == '0);
          if (sym_last) state_nxt = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          d_nxt = pay_lanes;
          if (sym_last) begin
            state_nxt = AFTER_PAY;
            done_nxt  = (AFTER_PAY == ST_SYNC);
          end
        end
`ifdef BSS_CRC8_EN
        ST_CRC: begin
          d_nxt = crc_lanes;
          if (sym_last) begin
            state_nxt = AFTER_DATA;
            done_nxt  = (AFTER_DATA == ST_SYNC);
          end
        end
`endif
        ST_GAP: begin
          d_nxt = '0;
          if (sym_last) begin
            state_nxt = ST_SYNC;
            done_nxt  = 1'b1;
          end
        end
        default: begin
          d_nxt     = '0;
          state_nxt = ST_SYNC;
        end
      endcase
    end
  end
endmodule
